// File: rtl/aes_drain_pkg.sv
// Shared types and sizes for the cipher result drain (128-bit block -> 4 x 32-bit beats).
// Build option AES_DRAIN_BYTESWAP_EN byte-reverses each output word.
package aes_drain_pkg;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef logic [1:0] beat_idx_t;

  typedef enum logic {S_IDLE, S_DRAIN} drain_state_t;

endpackage

// File: rtl/aes_drain_word_sel.sv
// Selects the 32-bit slice of a block for a beat index; beat 0 is bits [127:96].
// With AES_DRAIN_BYTESWAP_EN defined the selected word is byte-reversed.
module aes_drain_word_sel
  import aes_drain_pkg::*;
(
  input  logic [BLK_W-1:0]  blk_i,
  input  beat_idx_t         idx_i,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] slice;

  always_comb begin
    slice = blk_i[127:96];
    case (idx_i)
      2'd0:    slice = blk_i[127:96];
      2'd1:    slice = blk_i[95:64];
      2'd2:    slice = blk_i[63:32];
      default: slice = blk_i[31:0];
    endcase
  end

`ifdef AES_DRAIN_BYTESWAP_EN
  assign word_o = {slice[7:0], slice[15:8], slice[23:16], slice[31:24]};
`else
  assign word_o = slice;
`endif

endmodule

// File: rtl/aes_text_out_drain.sv
// Captures cipher result blocks on done and streams them as four words over valid/ready,
// with one pending block of skid storage and a sticky drop flag. Option: AES_DRAIN_BYTESWAP_EN.
module aes_text_out_drain #(
  parameter int WORD_W = aes_drain_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [127:0]      text_out,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              ovf,
  input  logic              ovf_clr
);

  import aes_drain_pkg::BLK_W;
  import aes_drain_pkg::BEATS;
  import aes_drain_pkg::beat_idx_t;
  import aes_drain_pkg::drain_state_t;
  import aes_drain_pkg::S_IDLE;
  import aes_drain_pkg::S_DRAIN;

  localparam beat_idx_t LAST_IDX = beat_idx_t'(BEATS - 1);

  // Handshake: a beat transfers when out_valid && out_ready; out_data is held while stalled.
  logic [BLK_W-1:0] act_q, act_d;
  logic [BLK_W-1:0] pend_q, pend_d;
  logic             act_vld_q, act_vld_d;
  logic             pend_vld_q, pend_vld_d;
  beat_idx_t        idx_q, idx_d;
  logic             ovf_q, ovf_d;

  drain_state_t     state;
  logic             beat, blk_end, act_free, pend_free, drop;

  assign state = act_vld_q ? S_DRAIN : S_IDLE;

  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    act_vld_d  = act_vld_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;

    beat    = (state == S_DRAIN) && out_ready;
    blk_end = beat && (idx_q == LAST_IDX);

    // Slot availability accounts for a block end happening in this same cycle.
    act_free  = (state == S_IDLE) || (blk_end && !pend_vld_q);
    pend_free = !pend_vld_q || blk_end;
    drop      = done && !act_free && !pend_free;

    if (beat) begin
      if (blk_end) begin
        idx_d = '0;
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end else begin
          act_vld_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    if (done) begin
      if (act_free) begin
        act_d     = text_out;
        act_vld_d = 1'b1;
        idx_d     = '0;
      end else if (pend_free) begin
        pend_d     = text_out;
        pend_vld_d = 1'b1;
      end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q      <= '0;
      pend_q     <= '0;
      act_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      act_vld_q  <= act_vld_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
    end
  end

  aes_drain_word_sel u_word_sel (
    .blk_i  (act_q),
    .idx_i  (idx_q),
    .word_o (out_data)
  );

  assign out_valid = (state == S_DRAIN);
  assign out_last  = (state == S_DRAIN) && (idx_q == LAST_IDX);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_aes_text_out_drain.sv
// Directed bench for aes_text_out_drain: scoreboard queue of expected {last, word} beats
// checked by a negedge monitor, plus inline timing checks. Honors AES_DRAIN_BYTESWAP_EN.
module tb_aes_text_out_drain;

  logic         clk;
  logic         rst;
  logic         done;
  logic [127:0] text_out;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         ovf;
  logic         ovf_clr;

  logic [32:0]  exp_q[$];
  int           checks;
  int           errors;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_B = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] BLK_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] BLK_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

  aes_text_out_drain #(.WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .text_out  (text_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_DRAIN_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // driver tasks
  task automatic push_block(input logic [127:0] blk);
    exp_q.push_back({1'b0, exp_word(blk[127:96])});
    exp_q.push_back({1'b0, exp_word(blk[95:64])});
    exp_q.push_back({1'b0, exp_word(blk[63:32])});
    exp_q.push_back({1'b1, exp_word(blk[31:0])});
  endtask

  task automatic send_done(input logic [127:0] blk);
    done     = 1'b1;
    text_out = blk;
    @(posedge clk);
    #1;
    done     = 1'b0;
    text_out = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 128'(out_valid), 128'(1'b0));
      end else if (out_ready) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 128'(out_data), 128'(e[31:0]));
        chk("beat_last", 128'(out_last), 128'(e[32]));
      end else begin
        chk("stall_hold", 128'(out_data), 128'(exp_q[0][31:0]));
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    done      = 1'b0;
    text_out  = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // reset state
    cycles(2);
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_last", 128'(out_last), 128'(1'b0));
    chk("rst_ovf", 128'(ovf), 128'(1'b0));
    chk("rst_data", 128'(out_data), 128'(32'h0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);

    // single block, ready high
    out_ready = 1'b1;
    push_block(BLK_A);
    send_done(BLK_A);
    @(negedge clk);
    chk("single_lat_valid", 128'(out_valid), 128'(1'b1));
    chk("single_beat0", 128'(out_data), 128'(exp_word(32'h00112233)));
    cycles(4);
    @(negedge clk);
    chk("single_idle", 128'(out_valid), 128'(1'b0));
    chk("single_q_empty", 128'(exp_q.size()), 128'(0));
    cycles(1);

    // backpressure during beat 1
    push_block(BLK_A);
    send_done(BLK_A);
    cycles(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_held", 128'(out_data), 128'(exp_word(32'h44556677)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(4);
    @(negedge clk);
    chk("bp_idle", 128'(out_valid), 128'(1'b0));
    chk("bp_q_empty", 128'(exp_q.size()), 128'(0));
    cycles(1);

    // back-to-back: second done two cycles after the first, no bubble
    push_block(BLK_A);
    push_block(BLK_B);
    send_done(BLK_A);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_valid", 128'(out_valid), 128'(1'b1));
      if (i == 4) chk("b2b_b_first", 128'(out_data), 128'(exp_word(32'hA0A1A2A3)));
      @(posedge clk);
      #1;
      done     = (i == 0);
      text_out = (i == 0) ? BLK_B : '0;
    end
    @(negedge clk);
    chk("b2b_idle", 128'(out_valid), 128'(1'b0));
    chk("b2b_ovf", 128'(ovf), 128'(1'b0));
    chk("b2b_q_empty", 128'(exp_q.size()), 128'(0));
    cycles(1);

    // overflow: third block dropped while stalled
    out_ready = 1'b0;
    push_block(BLK_A);
    push_block(BLK_B);
    send_done(BLK_A);
    send_done(BLK_B);
    @(negedge clk);
    chk("ovf_before_drop", 128'(ovf), 128'(1'b0));
    send_done(BLK_C);
    @(negedge clk);
    chk("ovf_set", 128'(ovf), 128'(1'b1));
    out_ready = 1'b1;
    cycles(8);
    @(negedge clk);
    chk("ovf_idle", 128'(out_valid), 128'(1'b0));
    chk("ovf_sticky", 128'(ovf), 128'(1'b1));
    chk("ovf_q_empty", 128'(exp_q.size()), 128'(0));
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 128'(ovf), 128'(1'b0));
    cycles(1);

    // simultaneous block end with pending full and a new done
    out_ready = 1'b0;
    push_block(BLK_A);
    push_block(BLK_B);
    push_block(BLK_C);
    send_done(BLK_A);
    send_done(BLK_B);
    out_ready = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("sim_last_now", 128'(out_last), 128'(1'b1));
    send_done(BLK_C);
    @(negedge clk);
    chk("sim_no_drop", 128'(ovf), 128'(1'b0));
    cycles(8);
    @(negedge clk);
    chk("sim_idle", 128'(out_valid), 128'(1'b0));
    chk("sim_q_empty", 128'(exp_q.size()), 128'(0));
    cycles(1);

    // reset asserted mid-block
    push_block(BLK_D);
    send_done(BLK_D);
    cycles(1);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_mid_data", 128'(out_data), 128'(32'h0));
    exp_q.delete();
    done     = 1'b1;
    text_out = BLK_C;
    cycles(1);
    done     = 1'b0;
    text_out = '0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rst_done_ignored", 128'(out_valid), 128'(1'b0));
    chk("rst_no_ovf", 128'(ovf), 128'(1'b0));
    push_block(BLK_A);
    send_done(BLK_A);
    @(negedge clk);
    chk("post_rst_beat0", 128'(out_data), 128'(exp_word(32'h00112233)));
    cycles(4);
    @(negedge clk);
    chk("post_rst_idle", 128'(out_valid), 128'(1'b0));
    chk("final_q_empty", 128'(exp_q.size()), 128'(0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
